// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops CPU stores, queues bytes in a small FIFO
// and serialises them on tx; a status word is readable at STAT_ADDR.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0400,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0404
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_next;
  logic [BW-1:0]   r_baud, w_baud_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_tx, w_tx_next;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic            r_overflow;

  logic            w_tx_hit, w_stat_hit, w_push_req, w_push_ok, w_drop, w_clear;
  logic            w_pop, w_baud_end, w_has_data;
  logic [7:0]      w_head;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_tx_hit   = (addr == TX_ADDR);
  assign w_stat_hit = (addr == STAT_ADDR);
  assign w_push_req = mem_write && w_tx_hit;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push_ok  = w_push_req && ((r_count != DEPTH_C) || w_pop);
  assign w_drop     = w_push_req && !w_push_ok;
  assign w_clear    = mem_write && w_stat_hit && wdata[0];
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_has_data = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_unused   = &{1'b0, wdata[31:8]};

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next   = 1'b1;
        w_baud_next = '0;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
          w_bit_next   = '0;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
            w_bit_next   = r_bit + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (w_has_data) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_baud_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push_ok) r_count <= r_count - 1'b1;
      if (w_drop)       r_overflow <= 1'b1;
      else if (w_clear) r_overflow <= 1'b0;
    end
  end

  assign tx         = r_tx;
  assign fifo_full  = (r_count == DEPTH_C);
  assign fifo_empty = (r_count == '0);
  assign overflow   = r_overflow;
  assign w_status   = {16'h0000, 8'(r_count), 4'h0, r_overflow, (r_state != S_IDLE),
                       fifo_empty, fifo_full};
  assign hit        = w_tx_hit || w_stat_hit;
  assign rdata      = w_stat_hit ? w_status : 32'h0000_0000;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random store traffic, checked every
// cycle against a frame-timing model of the serial line and FIFO occupancy.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TXA   = 32'h0000_0400;
  localparam logic [31:0] STA   = 32'h0000_0404;
  localparam logic [31:0] OTH   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = STA;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic [31:0] rdata;
  logic        hit, tx, fifo_full, fifo_empty, overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes waiting, the frame on the wire and when it started.
  logic [7:0] m_pend[$];
  bit         m_active;
  int         m_fstart;
  int         m_edge;
  logic [7:0] m_cur;
  bit         m_ovf;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TX_ADDR     (TXA),
    .STAT_ADDR   (STA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .rdata     (rdata),
    .hit       (hit),
    .tx        (tx),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One rising edge: a frame occupies 10*CPB edges from its pop; the next pop may
  // happen on the very edge the previous frame ends.
  task automatic model_edge();
    int szb;
    bit pop;
    pop = 1'b0;
    m_edge++;
    if (m_active && (m_edge - m_fstart) == 10 * CPB) m_active = 1'b0;
    szb = m_pend.size();
    if (!m_active && szb > 0) begin
      pop      = 1'b1;
      m_cur    = m_pend.pop_front();
      m_active = 1'b1;
      m_fstart = m_edge;
    end
    if (mem_write && addr == TXA) begin
      if (szb < DEPTH || pop) m_pend.push_back(wdata[7:0]);
      else m_ovf = 1'b1;
    end else if (mem_write && addr == STA && wdata[0]) begin
      m_ovf = 1'b0;
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (m_edge - m_fstart) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[15:8] = 8'(m_pend.size());
    s[3]    = m_ovf;
    s[2]    = m_active;
    s[1]    = (m_pend.size() == 0);
    s[0]    = (m_pend.size() == DEPTH);
    return s;
  endfunction

  task automatic check_all();
    chk("tx", tx, exp_tx());
    chk("fifo_full", fifo_full, (m_pend.size() == DEPTH));
    chk("fifo_empty", fifo_empty, (m_pend.size() == 0));
    chk("overflow", overflow, m_ovf);
    chk("hit", hit, (addr == TXA || addr == STA));
    chk("rdata", rdata, (addr == STA) ? exp_status() : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    addr      = STA;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((m_active || m_pend.size() > 0) && guard < 1000) begin
      tick();
      guard++;
    end
    chk(tag, (guard < 1000), 1'b1);
  endtask

  initial begin
    logic [9:0] seq;
    int         r;
    seq    = 10'b11_0100_1010;
    m_edge = 0;
    model_reset();

    // 1: reset state
    #3 reset = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_rdata", rdata, 32'h0000_0002);
    chk("rst_hit", hit, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();

    // 2: single 0xA5 frame, bit by bit
    store(TXA, 32'h0000_00A5);
    chk("a5_before_pop", tx, 1'b1);
    for (int i = 0; i < 10 * CPB; i++) begin
      tick();
      chk("a5_bit", tx, seq[i / CPB]);
    end
    tick();
    chk("a5_idle_status", rdata, 32'h0000_0002);

    // 3: ten back-to-back stores, the tenth overflows
    for (int i = 0; i < 10; i++) begin
      store(TXA, 32'(i));
      if (i == 8) chk("burst_full", fifo_full, 1'b1);
    end
    #1;
    chk("burst_overflow", overflow, 1'b1);
    chk("burst_count", {24'h0, rdata[15:8]}, 32'd8);

    // 4: clear overflow while frames are in flight
    repeat (5) tick();
    store(STA, 32'h0000_0001);
    chk("clear_overflow", overflow, 1'b0);
    drain("burst_drain");
    tick();
    chk("burst_idle_status", rdata, 32'h0000_0002);

    // 5: store to an unmapped address
    addr      = OTH;
    wdata     = 32'h0000_00FF;
    mem_write = 1'b1;
    tick();
    chk("other_hit", hit, 1'b0);
    chk("other_rdata", rdata, 32'h0);
    mem_write = 1'b0;
    tick();
    chk("other_empty", fifo_empty, 1'b1);
    chk("other_tx", tx, 1'b1);

    // random store/read traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      mem_write = 1'b0;
      wdata     = $urandom;
      case (r)
        0, 1, 2, 3: begin addr = TXA; mem_write = 1'b1; end
        4:          begin addr = STA; mem_write = 1'b1; end
        5:          begin addr = OTH; mem_write = 1'b1; end
        6:          addr = $urandom;
        7:          addr = TXA;
        default:    addr = STA;
      endcase
      tick();
    end
    mem_write = 1'b0;
    addr      = STA;
    drain("rand_drain");

    // 6: asynchronous reset mid-frame with bytes queued
    for (int i = 0; i < 4; i++) store(TXA, 32'($urandom_range(0, 255)));
    repeat (10) tick();
    chk("mid_busy", rdata[2], 1'b1);
    chk("mid_count", {24'h0, rdata[15:8]}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_tx_high", tx, 1'b1);
    model_reset();
    check_all();
    tick();
    tick();
    reset = 1'b1;
    repeat (100) tick();
    chk("post_rst_empty", fifo_empty, 1'b1);
    chk("post_rst_tx", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
